// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, memory-wait and redirect sequencer for the 3-stage core
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
`timescale 1ns/1ps

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_de,
  input  logic [31:0]      instr_ex,
  input  logic             br_taken,
  input  logic             dmem_ack,
  output logic             forw_a,
  output logic             forw_b,
  output logic             stall_if,
  output logic             stall_de,
  output logic             flush_de,
  output logic             redirect,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_OP     = 5'b01100;

  // Counter only needs to reach MEM_TIMEOUT-1; it never wraps.
  localparam int              TMO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_REDIRECT = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_err_q, mem_err_d;

  logic [4:0] op_de, op_ex, rs1_de, rs2_de, rd_ex;
  logic       rs1_used, rs2_used, ex_writes, ex_fwd_ok;
  logic       fwd_a, fwd_b, load_use, mem_ex, taken_de;
  logic       sif_c, sde_c, fde_c, red_c, req_c;
  logic       unused_bits;

  assign op_de  = instr_de[6:2];
  assign op_ex  = instr_ex[6:2];
  assign rs1_de = instr_de[19:15];
  assign rs2_de = instr_de[24:20];
  assign rd_ex  = instr_ex[11:7];

  assign unused_bits = ^{instr_de[31:25], instr_de[14:7], instr_de[1:0],
                         instr_ex[31:12], instr_ex[1:0]};

  assign rs1_used  = !(op_de == OP_LUI || op_de == OP_AUIPC || op_de == OP_JAL);
  assign rs2_used  = (op_de == OP_OP) || (op_de == OP_STORE) || (op_de == OP_BRANCH);
  assign ex_writes = (rd_ex != 5'd0) && (op_ex != OP_STORE) && (op_ex != OP_BRANCH);
  // Loads and link results are not available on the ALU path in exec.
  assign ex_fwd_ok = (op_ex != OP_LOAD) && (op_ex != OP_JAL) && (op_ex != OP_JALR);

  assign fwd_a = ex_writes && ex_fwd_ok && rs1_used && (rd_ex == rs1_de);
  assign fwd_b = ex_writes && ex_fwd_ok && rs2_used && (rd_ex == rs2_de);

  assign load_use = (op_ex == OP_LOAD) && (rd_ex != 5'd0) &&
                    ((rs1_used && (rs1_de == rd_ex)) || (rs2_used && (rs2_de == rd_ex)));

  assign mem_ex   = (op_ex == OP_LOAD) || (op_ex == OP_STORE);
  assign taken_de = ((op_de == OP_BRANCH) && br_taken) || (op_de == OP_JAL) || (op_de == OP_JALR);

  // State, timeout counter and sticky fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state and stall/flush/redirect decisions in priority order.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    mem_err_d = mem_err_q;
    sif_c     = 1'b0;
    sde_c     = 1'b0;
    fde_c     = 1'b0;
    red_c     = 1'b0;
    req_c     = 1'b0;
    unique case (state_q)
      S_ERROR: begin
        sif_c = 1'b1;
        sde_c = 1'b1;
      end
      S_REDIRECT: begin
        // Exec now holds the transfer; the wrong-path decode instr is killed.
        red_c   = 1'b1;
        fde_c   = 1'b1;
        tmo_d   = '0;
        state_d = S_RUN;
      end
      default: begin
        if (mem_ex) begin
          req_c = 1'b1;
          if (!dmem_ack) begin
            sif_c = 1'b1;
            sde_c = 1'b1;
            if ((MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
              state_d   = S_ERROR;
              mem_err_d = 1'b1;
            end else begin
              state_d = S_MEM_WAIT;
              if (MEM_TIMEOUT != 0) tmo_d = tmo_q + TMO_W'(1);
            end
          end else if (load_use) begin
            // Bubble into exec; decode re-reads the regfile after writeback.
            sif_c   = 1'b1;
            fde_c   = 1'b1;
            tmo_d   = '0;
            state_d = S_RUN;
          end else begin
            tmo_d   = '0;
            state_d = taken_de ? S_REDIRECT : S_RUN;
          end
        end else begin
          tmo_d   = '0;
          state_d = taken_de ? S_REDIRECT : S_RUN;
        end
      end
    endcase
  end

  assign forw_a   = !rst && fwd_a;
  assign forw_b   = !rst && fwd_b;
  assign stall_if = !rst && sif_c;
  assign stall_de = !rst && sde_c;
  assign flush_de = !rst && fde_c;
  assign redirect = !rst && red_c;
  assign dmem_req = !rst && req_c;
  assign mem_err  = !rst && mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign stall_cnt_d = (sif_c && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = ((state_q == S_REDIRECT) && (flush_cnt_q != '1)) ?
                       flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = rst ? '0 : stall_cnt_q;
  assign flush_cnt = rst ? '0 : flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 3-stage core (Fetch → Decode/ALU → Exec/Mem/WB).
- Generates forwarding selects, stalls, bubbles and fetch redirect for the decode/execute datapath.
- Holds the pipeline across variable-latency data-memory accesses via a req/ack handshake.
- Sequences the one-cycle kill after taken branches and jumps.

Parameters:
- MEM_TIMEOUT, 64, max cycles to wait for dmem_ack before fault; 0 disables timeout.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- instr_de  in  32  instruction in decode stage.
- instr_ex  in  32  instruction in exec stage (decode/exec pipeline register output).
- br_taken  in  1  branch comparator result for instr_de.
- dmem_ack  in  1  single-cycle completion pulse from data memory.
- forw_a  out  1  rs1 operand select: ALU_ppl instead of regfile.
- forw_b  out  1  rs2 operand select: ALU_ppl instead of regfile.
- stall_if  out  1  hold PC and fetch register.
- stall_de  out  1  hold decode/exec pipeline registers.
- flush_de  out  1  load bubble into decode/exec registers.
- redirect  out  1  fetch takes target from ALU_ppl.
- dmem_req  out  1  data-memory request, level, held until ack.
- mem_err  out  1  sticky timeout fault.
- stall_cnt  out  CNT_W  stall-cycle counter; feature-gated.
- flush_cnt  out  CNT_W  redirect counter; feature-gated.

Behaviour:
- Opcode decode uses instr[6:2]:
  - LOAD 00000, STORE 01000, BRANCH 11000, JAL 11011, JALR 11001.
  - LUI 01101, AUIPC 00101, OPIMM 00100, OP 01100.
- Operand usage:
  - rs1 used: all except LUI, AUIPC, JAL.
  - rs2 used: OP, STORE, BRANCH.
- Exec writes rd when: rd≠0 and opcode ∉ {STORE, BRANCH}.
- Forwarding (comb):
  - forw_a = exec writes rd && rd_ex==rs1_de && rs1 used && opcode_ex ∉ {LOAD, JAL, JALR}.
  - forw_b uses the same rule on rs2.
- Load-use hazard: opcode_ex==LOAD, rd_ex≠0, rd_ex matches a used source of instr_de.
- FSM states: RUN, MEM_WAIT, REDIRECT, ERROR. Reset → RUN, timeout counter 0, mem_err 0.
- While rst=1: all outputs forced 0.
- RUN and MEM_WAIT share mem handling. When opcode_ex ∈ {LOAD, STORE}:
  - dmem_req=1.
  - Without ack: stall_if=1, stall_de=1, state→MEM_WAIT.
  - On the ack cycle with load-use hazard: stall_if=1, flush_de=1, stall_de=0. Bubble enters exec; decode re-reads regfile next cycle with written value.
  - On the ack cycle without hazard: all 0, pipeline advances; state→RUN.
- Same-cycle ack (zero wait) is legal; MEM_WAIT is never entered.
- MEM_WAIT timeout counter:
  - Increments each waiting cycle.
  - When it reaches MEM_TIMEOUT-1 without ack: →ERROR, mem_err=1.
- ERROR: stall_if=stall_de=1, dmem_req=0, held until rst.
- Taken transfer: (opcode_de==BRANCH && br_taken) or opcode_de ∈ {JAL, JALR}, and stall_de=0 this cycle → next state REDIRECT.
- REDIRECT (exactly 1 cycle): redirect=1, flush_de=1 (kills wrong-path instr_de), then →RUN.
- No memory conflict in REDIRECT: exec holds the transfer instruction.
- Stalled decode: a transfer in decode is not acted on while stall_de=1 or during the load-use bubble; it is evaluated when it advances.
- Priority: rst > ERROR > memory stall > load-use bubble > REDIRECT entry.
- Latency: forwarding/stall outputs are combinational (0 cycles); redirect asserts 1 cycle after the transfer leaves decode.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle stall_if=1.
  - flush_cnt increments each REDIRECT cycle.
  - Both saturate at all-ones and clear on rst.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- ALU chain: instr_ex=addi x5,x0,1 (0x00100293), instr_de=add x6,x5,x5 → forw_a=1, forw_b=1, no stall. Same with rd=x0 → forw_a=forw_b=0.
- Store with 3-cycle memory: instr_ex=sw; ack on 3rd cycle → dmem_req high 3 cycles, stall_if=stall_de=1 first 2 cycles, all clear on ack cycle.
- Load-use: instr_ex=lw x7; instr_de=add x8,x7,x1; ack after 2 cycles → 1 stall cycle, then ack cycle stall_if=1, flush_de=1, stall_de=0, forw_a=0; next cycle no stall.
- Taken beq in decode (br_taken=1, no stall) → next cycle redirect=1, flush_de=1 for exactly one cycle; not-taken beq → no redirect. jal → redirect regardless of br_taken.
- Timeout with MEM_TIMEOUT=4, lw in exec, no ack → ERROR after 4 waiting cycles; mem_err=1, stalls held; rst → mem_err=0, RUN.
- With HAZARD_PERF_CNT_EN: run the load-use and beq scenarios → stall_cnt=2, flush_cnt=1. Mid-sequence rst clears counters and outputs in the reset cycle.
